// File: rtl/seq_right_shifter_pkg.sv
// Shared definitions for the sequential right shifter.
// Contents: the FSM state enum, the mode encodings and the data/count widths.
package seq_right_shifter_pkg;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    localparam logic MODE_SRA = 1'b0;
    localparam logic MODE_ROR = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/seq_right_shifter_if.sv
// Request/result bundle for the sequential right shifter.
// Signals:
//   start        request strobe (only accepted while idle)
//   In/Value/Mode operand, shift amount, 0=SRA 1=ROR
//   busy         operation in progress, including the done cycle
//   done         one-cycle pulse, Out/Zero valid
//   Out/Zero     result register and its zero flag
// Modports: master drives the request, slave is the shifter.
interface seq_right_shifter_if;
    import seq_right_shifter_pkg::*;

    logic              start;
    logic [DATA_W-1:0] In;
    logic [CNT_W-1:0]  Value;
    logic              Mode;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] Out;
    logic              Zero;

    modport master (output start, In, Value, Mode, input busy, done, Out, Zero);
    modport slave  (input start, In, Value, Mode, output busy, done, Out, Zero);
endinterface

// File: rtl/right_shift_step.sv
// One-bit right shift step (combinational).
// Ports:
//   data  operand
//   mode  MODE_SRA replicates the sign bit, MODE_ROR wraps bit 0 to the top
//   q     data shifted right by one position
module right_shift_step
    import seq_right_shifter_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic              mode,
    output logic [DATA_W-1:0] q
);
    logic fill;

    assign fill = (mode == MODE_ROR) ? data[0] : data[DATA_W-1];
    assign q    = {fill, data[DATA_W-1:1]};
endmodule

// File: rtl/seq_right_shifter.sv
// Sequential arithmetic-shift / rotate-right unit, one bit per cycle.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  slave side of seq_right_shifter_if (start/In/Value/Mode in,
//        busy/done/Out/Zero out)
// A start in IDLE latches the operands; SHIFT runs Value cycles, then DONE
// pulses done for one cycle with Out/Zero already holding the result.
module seq_right_shifter
    import seq_right_shifter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    seq_right_shifter_if.slave bus
);
    state_t            state, state_n;
    logic [DATA_W-1:0] work, work_n, step_q;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              mode_q, mode_n;
    logic [DATA_W-1:0] out_q;
    logic              zero_q;

    right_shift_step u_step (
        .data (work),
        .mode (mode_q),
        .q    (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        work_n  = work;
        cnt_n   = cnt;
        mode_n  = mode_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    work_n  = bus.In;
                    cnt_n   = bus.Value;
                    mode_n  = bus.Mode;
                    state_n = (bus.Value != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                work_n = step_q;
                cnt_n  = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Results are captured on the edge that enters DONE, so Out/Zero are
    // already valid while done is high and stay frozen through later SHIFTs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work   <= '0;
            cnt    <= '0;
            mode_q <= MODE_SRA;
            out_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            work   <= work_n;
            cnt    <= cnt_n;
            mode_q <= mode_n;
            if (state_n == DONE) begin
                out_q  <= work_n;
                zero_q <= (work_n == '0);
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.Out  = out_q;
    assign bus.Zero = zero_q;
endmodule

// File: tb/tb_seq_right_shifter.sv
// Self-checking bench for seq_right_shifter: directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_seq_right_shifter;
    import seq_right_shifter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] last_out = 16'h0000;

    seq_right_shifter_if bus ();

    seq_right_shifter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_fn(input logic [15:0] d, input int v, input logic m);
        logic signed [15:0] s;
        logic [31:0]        dd;
        if (m == MODE_SRA) begin
            s = d;
            return 16'(s >>> v);
        end
        dd = {d, d} >> v;
        return dd[15:0];
    endfunction

    // Called at a negedge; returns at a negedge two cycles after done.
    // hammer keeps start high (with fresh operands) through SHIFT and DONE.
    task automatic run_op(input logic [15:0] din, input int v, input logic m, input bit hammer);
        logic [15:0] exp;
        int          lat;
        exp = ref_fn(din, v, m);
        bus.start = 1'b1;
        bus.In    = din;
        bus.Value = 4'(v);
        bus.Mode  = m;
        @(negedge clk);
        lat = 1;
        while (!bus.done && lat < 20) begin
            chk("busy_run", 32'(bus.busy), 32'd1);
            chk("out_hold", 32'(bus.Out), 32'(last_out));
            bus.start = hammer;
            bus.In    = 16'($urandom);
            bus.Value = 4'($urandom);
            bus.Mode  = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        bus.start = hammer;
        bus.In    = 16'($urandom);
        bus.Value = 4'($urandom);
        chk("latency", 32'(lat), 32'(v + 1));
        chk("done_busy", 32'(bus.busy), 32'd1);
        chk("out", 32'(bus.Out), 32'(exp));
        chk("zero", 32'(bus.Zero), 32'(exp == 16'h0));
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("done_pulse", 32'(bus.done), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("out_after", 32'(bus.Out), 32'(exp));
            @(negedge clk);
        end
        last_out = exp;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.In    = '0;
        bus.Value = '0;
        bus.Mode  = MODE_SRA;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_out", 32'(bus.Out), 32'h0);
        chk("rst_zero", 32'(bus.Zero), 32'd1);
        rst = 1'b0;

        run_op(16'h8000, 4, MODE_SRA, 1'b0);
        run_op(16'h0001, 1, MODE_ROR, 1'b0);
        run_op(16'h1234, 8, MODE_ROR, 1'b0);
        run_op(16'hA5A5, 0, MODE_SRA, 1'b0);
        run_op(16'hA5A5, 0, MODE_ROR, 1'b1);
        run_op(16'h7FFF, 15, MODE_SRA, 1'b0);
        run_op(16'hC3C3, 6, MODE_SRA, 1'b1);

        // Abort in the third SHIFT cycle, then restart on the first edge.
        bus.start = 1'b1;
        bus.In    = 16'h9ABC;
        bus.Value = 4'd10;
        bus.Mode  = MODE_SRA;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_out", 32'(bus.Out), 32'h0);
        chk("abort_zero", 32'(bus.Zero), 32'd1);
        @(negedge clk);
        chk("abort_nodone", 32'(bus.done), 32'd0);
        rst = 1'b0;
        last_out = 16'h0000;
        run_op(16'h9ABC, 10, MODE_SRA, 1'b0);

        for (int i = 0; i < 30; i++)
            run_op(16'($urandom), int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_right_shifter.md
SEQ_RIGHT_SHIFTER -- requirements
Module: seq_right_shifter

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous reset, active-high; clears all state on assertion.
REQ-004 start  input  1  request strobe; sampled on rising clk.
REQ-005 In  input  16  operand; captured only on an accepted start.
REQ-006 Value  input  4  shift amount 0..15; captured only on an accepted start.
REQ-007 Mode  input  1  operation select: 0 = SRA (arithmetic right), 1 = ROR (rotate right); captured only on an accepted start.
REQ-008 busy  output  1  high while an operation is in progress, including the done cycle.
REQ-009 done  output  1  one-cycle pulse; marks Out and Zero valid.
REQ-010 Out  output  16  result register.
REQ-011 Zero  output  1  high when Out == 16'h0000; updated together with Out.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 IDLE: start=1 is accepted; In, Value and Mode are latched; the remaining-count register is loaded with Value; next state is SHIFT if Value != 0, otherwise DONE.
REQ-014 SHIFT: working register shifts right by exactly 1 bit per cycle and the count decrements by 1; on the cycle the count reaches 0 the next state is DONE.
REQ-015 SRA step: bit 15 is replicated into bit 15 and bits [15:1] move into bits [14:0].
REQ-016 ROR step: bit 0 moves to bit 15 and bits [15:1] move into bits [14:0].
REQ-017 DONE: done=1 for exactly one cycle, Out and Zero are loaded from the working register, and next state is IDLE.
REQ-018 Latency from the accepted start edge to the done cycle SHALL be Value+1 cycles (Value=0 gives 1 cycle; Value=15 gives 16 cycles).
REQ-019 start asserted in SHIFT or DONE SHALL be ignored: no relatch and no queueing.
REQ-020 start in the same cycle that done is high SHALL be ignored; a new start is accepted only in IDLE.
REQ-021 Out and Zero SHALL hold their values from done until the next done; they SHALL NOT change during SHIFT.
REQ-022 Changes on In, Value or Mode after acceptance SHALL NOT affect the operation in flight.
REQ-023 busy SHALL equal (state != IDLE).
REQ-024 Shift amount SHALL be taken modulo 16 with no saturation; there is no overflow output.

Reset
REQ-025 On rst: state=IDLE, busy=0, done=0, Out=16'h0000, Zero=1, working and count registers=0.
REQ-026 rst asserted mid-operation SHALL abort the operation with no done pulse; after release the block accepts start on the first rising edge.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE/SHIFT/DONE), the mode constants (MODE_SRA=1'b0, MODE_ROR=1'b1) and the data width (16).
REQ-028 The single-bit step SHALL be a combinational sub-module right_shift_step (inputs: data, mode; output: data shifted by 1). The FSM, count, working register and output registers SHALL live in seq_right_shifter.

Verification
REQ-029 SRA, In=16'h8000, Value=4 -> done 5 cycles after start, Out=16'hF800, Zero=0.
REQ-030 ROR, In=16'h0001, Value=1 -> done 2 cycles after start, Out=16'h8000; ROR, In=16'h1234, Value=8 -> Out=16'h3412.
REQ-031 Value=0, In=16'hA5A5, either mode -> done 1 cycle after start, Out=16'hA5A5.
REQ-032 SRA, In=16'h7FFF, Value=15 -> done 16 cycles after start, Out=16'h0000, Zero=1.
REQ-033 A second start during SHIFT with different In -> first result unchanged; one done pulse only; busy stays high until after done.
REQ-034 rst pulsed in the 3rd SHIFT cycle of SRA Value=10 -> no done; Out=0, Zero=1; a start on the first post-reset edge completes normally.
